// File: rtl/mini_alu_param.sv
// rtl/mini_alu_param.sv - two-stage fetch/execute mini ALU with register file and iterative multiplier

module mini_alu_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [IP_W-1:0]       oIP,
  input  logic [4+3*ADDR_W-1:0] iInstruction,
  output logic [LED_W-1:0]      oLed,
  output logic                  oBusy,
  output logic                  oHalted,
  output logic                  oCarry
);

  localparam int INSTR_W = 4 + 3*ADDR_W;
  localparam int DEPTH   = 2**ADDR_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_LED = 4'd1;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;

  logic [IP_W-1:0]    ip_q, ip_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               halted_q, halted_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [DATA_W-1:0]  mul_acc_q, mul_acc_d;
  logic [DATA_W-1:0]  mul_a_q, mul_a_d;
  logic [DATA_W-1:0]  mul_b_q, mul_b_d;
  logic [DATA_W-1:0]  rf_q [DEPTH];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] dst, src1, src0;
  logic [DATA_W-1:0] rd1, rd0;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              mul_first, mul_last;
  logic [DATA_W-1:0] a_cur, b_cur, acc_cur, acc_next;

  assign opcode = ir_q[INSTR_W-1 -: 4];
  assign dst    = ir_q[3*ADDR_W-1 -: ADDR_W];
  assign src1   = ir_q[2*ADDR_W-1 -: ADDR_W];
  assign src0   = ir_q[ADDR_W-1:0];
  assign rd1    = rf_q[src1];
  assign rd0    = rf_q[src0];

  // Shift-add step: the first cycle takes operands straight from the register file
  always_comb begin
    mul_first = (mul_cnt_q == '0);
    mul_last  = (mul_cnt_q == CNT_W'(DATA_W - 1));
    a_cur     = mul_first ? rd1 : mul_a_q;
    b_cur     = mul_first ? rd0 : mul_b_q;
    acc_cur   = mul_first ? '0 : mul_acc_q;
    acc_next  = acc_cur + (b_cur[0] ? a_cur : '0);
  end

  // Fetch advance, execute decode and commit values; a halted core does nothing
  always_comb begin
    ip_d      = ip_q;
    ir_d      = ir_q;
    led_d     = led_q;
    halted_d  = halted_q;
    carry_d   = carry_q;
    mul_cnt_d = mul_cnt_q;
    mul_acc_d = mul_acc_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    wr_en     = 1'b0;
    wr_data   = '0;
    busy      = 1'b0;
    if (!halted_q) begin
      ip_d = ip_q + 1'b1;
      ir_d = iInstruction;
      case (opcode)
        OP_LED: led_d = rd1[LED_W-1:0];
        OP_BLE: begin
          if (rd1 <= rd0) begin
            ip_d = IP_W'(dst);
            ir_d = '0;
          end
        end
        OP_STO: begin
          wr_en   = 1'b1;
          wr_data = DATA_W'({src1, src0});
        end
        OP_ADD: begin
          wr_en              = 1'b1;
          {carry_d, wr_data} = {1'b0, rd1} + {1'b0, rd0};
        end
        OP_JMP: begin
          ip_d = IP_W'(dst);
          ir_d = '0;
        end
        OP_SUB: begin
          wr_en   = 1'b1;
          wr_data = rd1 - rd0;
          carry_d = (rd1 < rd0);
        end
        OP_MUL: begin
          mul_acc_d = acc_next;
          mul_a_d   = a_cur << 1;
          mul_b_d   = b_cur >> 1;
          if (mul_last) begin
            wr_en     = 1'b1;
            wr_data   = acc_next;
            mul_cnt_d = '0;
          end else begin
            busy      = 1'b1;
            mul_cnt_d = mul_cnt_q + 1'b1;
            ip_d      = ip_q;
            ir_d      = ir_q;
          end
        end
        OP_HLT: begin
          halted_d = 1'b1;
          ip_d     = ip_q;
          ir_d     = ir_q;
        end
        default: ;
      endcase
    end
  end

  // Pipeline, status and multiplier state registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip_q      <= '0;
      ir_q      <= '0;
      led_q     <= '0;
      halted_q  <= 1'b0;
      carry_q   <= 1'b0;
      mul_cnt_q <= '0;
      mul_acc_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      ip_q      <= ip_d;
      ir_q      <= ir_d;
      led_q     <= led_d;
      halted_q  <= halted_d;
      carry_q   <= carry_d;
      mul_cnt_q <= mul_cnt_d;
      mul_acc_q <= mul_acc_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  // Register file: cleared on reset, one write per cycle at DST
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[dst] <= wr_data;
    end
  end

  assign oIP     = ip_q;
  assign oLed    = led_q;
  assign oBusy   = busy;
  assign oHalted = halted_q;
  assign oCarry  = carry_q;

endmodule

// File: tb/tb_mini_alu_param.sv
// tb/tb_mini_alu_param.sv - directed self-checking bench for mini_alu_param

module tb_mini_alu_param;

  logic        Clock;
  logic        Reset;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [15:0] oLed;
  logic        oBusy;
  logic        oHalted;
  logic        oCarry;

  logic [27:0] rom [0:255];
  int errors = 0;
  int checks = 0;

  mini_alu_param #(.DATA_W(16), .ADDR_W(8), .IP_W(16), .LED_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oLed(oLed), .oBusy(oBusy), .oHalted(oHalted), .oCarry(oCarry)
  );

  assign iInstruction = rom[oIP[7:0]];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'd3, d, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    checks++; if (oIP !== 16'h0) begin errors++; $display("FAIL reset_ip: got %h expected 0000", oIP); end
    checks++; if (oLed !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected 0000", oLed); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    checks++; if (oHalted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", oHalted); end
    checks++; if (oCarry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", oCarry); end
  endtask

  task automatic test_add();
    clear_rom();
    rom[0] = sto(8'd1, 16'h0003);
    rom[1] = sto(8'd2, 16'h0005);
    rom[2] = ins(4'd4, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    do_reset();
    tick(5);
    checks++; if (oLed !== 16'h0008) begin errors++; $display("FAIL add_led: got %h expected 0008", oLed); end
    checks++; if (oCarry !== 1'b0) begin errors++; $display("FAIL add_carry: got %b expected 0", oCarry); end
    checks++; if (oIP !== 16'h0005) begin errors++; $display("FAIL add_ip: got %h expected 0005", oIP); end
  endtask

  task automatic test_carry();
    clear_rom();
    rom[0] = sto(8'd1, 16'hFFFF);
    rom[1] = sto(8'd2, 16'h0001);
    rom[2] = ins(4'd1, 8'd0, 8'd1, 8'd0);
    rom[3] = ins(4'd4, 8'd3, 8'd1, 8'd2);
    rom[4] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    rom[5] = ins(4'd6, 8'd4, 8'd2, 8'd1);
    rom[6] = ins(4'd1, 8'd0, 8'd4, 8'd0);
    rom[7] = ins(4'd6, 8'd5, 8'd1, 8'd2);
    rom[8] = ins(4'd1, 8'd0, 8'd5, 8'd0);
    do_reset();
    tick(4);
    checks++; if (oLed !== 16'hFFFF) begin errors++; $display("FAIL sto_ffff_led: got %h expected ffff", oLed); end
    tick(1);
    checks++; if (oCarry !== 1'b1) begin errors++; $display("FAIL add_wrap_carry: got %b expected 1", oCarry); end
    tick(1);
    checks++; if (oLed !== 16'h0000) begin errors++; $display("FAIL add_wrap_led: got %h expected 0000", oLed); end
    tick(2);
    checks++; if (oLed !== 16'h0002) begin errors++; $display("FAIL sub_borrow_led: got %h expected 0002", oLed); end
    checks++; if (oCarry !== 1'b1) begin errors++; $display("FAIL sub_borrow_carry: got %b expected 1", oCarry); end
    tick(2);
    checks++; if (oLed !== 16'hFFFE) begin errors++; $display("FAIL sub_noborrow_led: got %h expected fffe", oLed); end
    checks++; if (oCarry !== 1'b0) begin errors++; $display("FAIL sub_noborrow_carry: got %b expected 0", oCarry); end
  endtask

  task automatic test_mul();
    int busy_cnt;
    int ip_bad;
    clear_rom();
    rom[0] = sto(8'd1, 16'h0007);
    rom[1] = sto(8'd2, 16'h0009);
    rom[2] = ins(4'd7, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    rom[4] = sto(8'd4, 16'hFFFF);
    rom[5] = ins(4'd7, 8'd5, 8'd4, 8'd4);
    rom[6] = ins(4'd1, 8'd0, 8'd5, 8'd0);
    do_reset();
    tick(3);
    busy_cnt = 0;
    ip_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (oBusy === 1'b1) busy_cnt++;
      if (oIP !== 16'h0003) ip_bad++;
      tick(1);
    end
    checks++; if (busy_cnt != 15) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 15", busy_cnt); end
    checks++; if (ip_bad != 0) begin errors++; $display("FAIL mul_ip_hold: got %0d moved cycles expected 0", ip_bad); end
    checks++; if (oIP !== 16'h0004) begin errors++; $display("FAIL mul_resume_ip: got %h expected 0004", oIP); end
    tick(1);
    checks++; if (oLed !== 16'h003F) begin errors++; $display("FAIL mul_7x9: got %h expected 003f", oLed); end
    tick(20);
    checks++; if (oLed !== 16'h0001) begin errors++; $display("FAIL mul_ffff_sq: got %h expected 0001", oLed); end
  endtask

  task automatic test_ble();
    clear_rom();
    rom[0]  = sto(8'd1, 16'h0004);
    rom[1]  = sto(8'd2, 16'h0004);
    rom[2]  = ins(4'd2, 8'h10, 8'd2, 8'd1);
    rom[3]  = sto(8'd2, 16'h0055);
    rom[16] = ins(4'd1, 8'd0, 8'd2, 8'd0);
    do_reset();
    tick(4);
    checks++; if (oIP !== 16'h0010) begin errors++; $display("FAIL ble_taken_ip: got %h expected 0010", oIP); end
    tick(1);
    checks++; if (oIP !== 16'h0011) begin errors++; $display("FAIL ble_bubble_ip: got %h expected 0011", oIP); end
    tick(1);
    checks++; if (oLed !== 16'h0004) begin errors++; $display("FAIL ble_discard_led: got %h expected 0004", oLed); end
    clear_rom();
    rom[0] = sto(8'd1, 16'h0004);
    rom[1] = sto(8'd2, 16'h0005);
    rom[2] = ins(4'd2, 8'h10, 8'd2, 8'd1);
    rom[3] = ins(4'd1, 8'd0, 8'd2, 8'd0);
    do_reset();
    tick(4);
    checks++; if (oIP !== 16'h0004) begin errors++; $display("FAIL ble_not_taken_ip: got %h expected 0004", oIP); end
    tick(1);
    checks++; if (oLed !== 16'h0005) begin errors++; $display("FAIL ble_not_taken_led: got %h expected 0005", oLed); end
  endtask

  task automatic test_misc_ops();
    clear_rom();
    rom[0] = sto(8'd1, 16'h0005);
    rom[1] = ins(4'd9, 8'd1, 8'd0, 8'd0);
    rom[2] = ins(4'd15, 8'h20, 8'd0, 8'd0);
    rom[3] = sto(8'd5, 16'h0003);
    rom[4] = ins(4'd4, 8'd5, 8'd5, 8'd5);
    rom[5] = ins(4'd4, 8'd5, 8'd5, 8'd5);
    rom[6] = ins(4'd1, 8'd0, 8'd5, 8'd0);
    rom[7] = ins(4'd1, 8'd0, 8'd1, 8'd0);
    do_reset();
    tick(8);
    checks++; if (oLed !== 16'h000C) begin errors++; $display("FAIL same_reg_add: got %h expected 000c", oLed); end
    tick(1);
    checks++; if (oLed !== 16'h0005) begin errors++; $display("FAIL illegal_op_nowrite: got %h expected 0005", oLed); end
    checks++; if (oIP !== 16'h0009) begin errors++; $display("FAIL illegal_op_nobranch: got %h expected 0009", oIP); end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = sto(8'd1, 16'h0042);
    rom[1] = ins(4'd1, 8'd0, 8'd1, 8'd0);
    rom[2] = sto(8'd3, 16'h0077);
    rom[6] = ins(4'd8, 8'd0, 8'd0, 8'd0);
    rom[7] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    do_reset();
    tick(7);
    checks++; if (oHalted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", oHalted); end
    tick(1);
    checks++; if (oHalted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", oHalted); end
    checks++; if (oIP !== 16'h0007) begin errors++; $display("FAIL halt_ip: got %h expected 0007", oIP); end
    tick(5);
    checks++; if (oIP !== 16'h0007) begin errors++; $display("FAIL halt_ip_frozen: got %h expected 0007", oIP); end
    checks++; if (oLed !== 16'h0042) begin errors++; $display("FAIL halt_led_frozen: got %h expected 0042", oLed); end
    Reset = 1'b0;
    #1;
    checks++; if (oHalted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag: got %b expected 0", oHalted); end
    checks++; if (oIP !== 16'h0000) begin errors++; $display("FAIL halt_reset_ip: got %h expected 0000", oIP); end
  endtask

  task automatic test_mul_reset();
    clear_rom();
    rom[0] = sto(8'd1, 16'h0007);
    rom[1] = sto(8'd2, 16'h0009);
    rom[2] = ins(4'd7, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    do_reset();
    tick(7);
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL mulrst_busy_before: got %b expected 1", oBusy); end
    Reset = 1'b0;
    #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL mulrst_busy_drop: got %b expected 0", oBusy); end
    checks++; if (oIP !== 16'h0000) begin errors++; $display("FAIL mulrst_ip: got %h expected 0000", oIP); end
    clear_rom();
    rom[0] = sto(8'd4, 16'h0011);
    rom[1] = ins(4'd1, 8'd0, 8'd4, 8'd0);
    rom[2] = ins(4'd1, 8'd0, 8'd3, 8'd0);
    do_reset();
    tick(1);
    checks++; if (oIP !== 16'h0001) begin errors++; $display("FAIL mulrst_restart_ip: got %h expected 0001", oIP); end
    tick(2);
    checks++; if (oLed !== 16'h0011) begin errors++; $display("FAIL mulrst_led_marker: got %h expected 0011", oLed); end
    tick(1);
    checks++; if (oLed !== 16'h0000) begin errors++; $display("FAIL mulrst_dst_clear: got %h expected 0000", oLed); end
  endtask

  initial begin
    Reset = 1'b1;
    clear_rom();
    test_reset();
    test_add();
    test_carry();
    test_mul();
    test_ble();
    test_misc_ops();
    test_halt();
    test_mul_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
